// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//   Coprocessor-0 exception / interrupt controller sitting at the M stage.
//   Decides whether the instruction in M traps (synchronous exception code
//   carried down the pipe, or an enabled hardware interrupt). It holds the
//   SR, Cause and EPC registers, returns PRId, and serves mfc0, mtc0 and eret.
//
// Ports
//   clk        in   1   system clock, all state on rising edge
//   reset_n    in   1   asynchronous active-low reset
//   PCIn       in   32  PC of the instruction in M (victim PC)
//   BDIn       in   1   M instruction is in a branch delay slot
//   ExcCodeIn  in   5   accumulated exception code, 0 = none
//   HWInt      in   6   level-sensitive hardware interrupt lines
//   CP0Addr    in   5   mfc0/mtc0 register number
//   CP0WE      in   1   mtc0 in M
//   CP0WD      in   32  mtc0 write data
//   EXLClr     in   1   eret in M
//   CP0RD      out  32  mfc0 read data (combinational, pre-edge state)
//   IntReq     out  1   trap this cycle: flush and redirect to HandlerPC
//   EPCOut     out  32  current EPC register (eret target)
//   HandlerPC  out  32  constant exception entry address
//
// There is no handshake: IntReq is a single-cycle combinational request that
// the pipeline must act on in the same cycle it is asserted.
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID       = 32'h0000_7777,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] PCIn,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  CP0Addr,
  input  logic        CP0WE,
  input  logic [31:0] CP0WD,
  input  logic        EXLClr,
  output logic [31:0] CP0RD,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  // EPC
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts win over synchronous exceptions; both are masked while EXL=1.
  assign int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign IntReq   = int_pend | exc_pend;

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign victim_pc = BDIn ? (PCIn - 32'd4) : PCIn;

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        // The trapping instruction is flushed, so any mtc0/eret it carries
        // is dropped.
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= int_pend ? 5'd0 : ExcCodeIn;
        epc       <= {victim_pc[31:2], 2'b00};
      end else begin
        if (CP0WE) begin
          case (CP0Addr)
            ADDR_SR: begin
              sr_im  <= CP0WD[15:10];
              sr_exl <= CP0WD[1];
              sr_ie  <= CP0WD[0];
            end
            ADDR_EPC: epc <= CP0WD;
            default: ;
          endcase
        end
        // Placed after the mtc0 so eret overrides an SR write in the same cycle.
        if (EXLClr) sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    CP0RD = 32'd0;
    case (CP0Addr)
      ADDR_SR:    CP0RD = sr_word;
      ADDR_CAUSE: CP0RD = cause_word;
      ADDR_EPC:   CP0RD = epc;
      ADDR_PRID:  CP0RD = PRID;
      default:    CP0RD = 32'd0;
    endcase
  end

  assign EPCOut    = epc;
  assign HandlerPC = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//   Drives cp0_exc_ctrl one cycle at a time. For each cycle the driver asks a
//   word-level model of CP0 for the expected {IntReq, CP0RD, EPCOut} and
//   pushes it on exp_q; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID       = 32'h0000_7777;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam int W = 65;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_in;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wd;
  logic        exl_clr;
  logic [31:0] cp0_rd;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  cp0_exc_ctrl #(.PRID(PRID), .HANDLER_PC(HANDLER_PC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .PCIn      (pc_in),
    .BDIn      (bd_in),
    .ExcCodeIn (exc_in),
    .HWInt     (hw_int),
    .CP0Addr   (cp0_addr),
    .CP0WE     (cp0_we),
    .CP0WD     (cp0_wd),
    .EXLClr    (exl_clr),
    .CP0RD     (cp0_rd),
    .IntReq    (int_req),
    .EPCOut    (epc_out),
    .HandlerPC (handler_pc)
  );

  // ---------------- reference model ----------------
  // Registers held as whole 32-bit words, exactly as software reads them.
  logic [31:0] m_sr, m_cause, m_epc;
  logic        m_int, m_trap;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_eval();
    logic exl, ie;
    logic [5:0] im;
    exl = m_sr[1];
    ie  = m_sr[0];
    im  = m_sr[15:10];
    m_int  = ((hw_int & im) != 6'd0) && ie && !exl;
    m_trap = m_int || ((exc_in != 5'd0) && !exl);
  endtask

  task automatic model_edge();
    logic [31:0] code;
    if (!reset_n) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (m_trap) begin
      code    = m_int ? 32'd0 : 32'(exc_in);
      m_sr    = m_sr | 32'd2;
      m_cause = (32'(bd_in) << 31) | (32'(hw_int) << 10) | (code << 2);
      m_epc   = (bd_in ? pc_in - 32'd4 : pc_in) & ~32'd3;
    end else begin
      m_cause = (m_cause & ~(32'h3F << 10)) | (32'(hw_int) << 10);
      if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_wd & SR_MASK;
      if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wd;
      if (exl_clr) m_sr = m_sr & ~32'd2;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (int_req !== e[64]) begin
        n_errors++;
        $display("FAIL intreq cyc=%0d got=%0b want=%0b", cyc, int_req, e[64]);
      end
      n_checks++;
      if (cp0_rd !== e[63:32]) begin
        n_errors++;
        $display("FAIL cp0rd cyc=%0d addr=%0d got=%h want=%h", cyc, cp0_addr, cp0_rd, e[63:32]);
      end
      n_checks++;
      if (epc_out !== e[31:0]) begin
        n_errors++;
        $display("FAIL epcout cyc=%0d got=%h want=%h", cyc, epc_out, e[31:0]);
      end
      cyc++;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic [5:0] hw,
                      input logic [4:0] addr, input logic we,
                      input logic [31:0] wd, input logic clr);
    reset_n = rst; pc_in = pc; bd_in = bd; exc_in = exc; hw_int = hw;
    cp0_addr = addr; cp0_we = we; cp0_wd = wd; exl_clr = clr;
    if (!rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end
    model_eval();
    exp_q.push_back({m_trap, model_read(addr), m_epc});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [5:0] hw);
    step(1'b1, 32'h0, 1'b0, 5'd0, hw, addr, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd, input logic clr);
    step(1'b1, 32'h0, 1'b0, 5'd0, 6'd0, addr, 1'b1, wd, clr);
  endtask

  task automatic eret(input logic [5:0] hw);
    step(1'b1, 32'h0, 1'b0, 5'd0, hw, 5'd12, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic trap(input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                      input logic [5:0] hw);
    step(1'b1, pc, bd, exc, hw, 5'd13, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset_n = 1'b0; pc_in = 0; bd_in = 0; exc_in = 0; hw_int = 0;
    cp0_addr = 0; cp0_we = 0; cp0_wd = 0; exl_clr = 0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 5'd12, 1'b0, 32'h0, 1'b0);

    n_checks++;
    if (handler_pc !== HANDLER_PC) begin
      n_errors++;
      $display("FAIL handler_pc got=%h want=%h", handler_pc, HANDLER_PC);
    end

    // Reset state of all readable registers
    rd(5'd12, 0); rd(5'd13, 0); rd(5'd14, 0); rd(5'd15, 0); rd(5'd3, 0);

    // RI exception, then read EPC/Cause/SR
    trap(32'h3010, 1'b0, 5'd10, 6'd0);
    rd(5'd14, 0); rd(5'd13, 0); rd(5'd12, 0);

    // Reset mid-run with EXL=1 and EPC=3008
    wr(5'd14, 32'h3008, 1'b0);
    rd(5'd14, 0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 5'd12, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 5'd14, 1'b0, 32'h0, 1'b0);
    rd(5'd12, 0);

    // Delay-slot exception, then eret
    trap(32'h3024, 1'b1, 5'd12, 6'd0);
    rd(5'd14, 0); rd(5'd13, 0);
    eret(0); rd(5'd12, 0);

    // Interrupt gating with IE=1, then IE=0
    wr(5'd12, 32'h0000_0401, 1'b0);
    trap(32'h3100, 1'b0, 5'd0, 6'b000001);
    rd(5'd13, 0); eret(0);
    wr(5'd12, 32'h0000_0400, 1'b0);
    trap(32'h3104, 1'b0, 5'd0, 6'b000001);
    rd(5'd13, 6'b000001);

    // Interrupt beats exception
    wr(5'd12, 32'h0000_0401, 1'b0);
    trap(32'h3030, 1'b0, 5'd4, 6'b000001);
    rd(5'd13, 0); eret(0);
    wr(5'd12, 32'h0, 1'b0);

    // Trap with simultaneous mtc0 to EPC
    step(1'b1, 32'h3040, 1'b0, 5'd8, 6'd0, 5'd14, 1'b1, 32'hDEAD_BEEF, 1'b0);
    rd(5'd14, 0); eret(0);

    // Nesting blocked while EXL=1, eret, pending interrupt retakes
    trap(32'h3050, 1'b0, 5'd5, 6'd0);
    trap(32'h3060, 1'b0, 5'd5, 6'd0);
    rd(5'd14, 0); rd(5'd13, 0);
    wr(5'd12, 32'h0000_0403, 1'b0);
    rd(5'd12, 6'b000001);
    eret(6'b000001);
    trap(32'h3070, 1'b0, 5'd0, 6'b000001);
    rd(5'd13, 6'b000001);

    // eret together with mtc0 to SR: EXL forced 0
    wr(5'd12, 32'h0000_0003, 1'b1);
    rd(5'd12, 0);
    wr(5'd12, 32'h0, 1'b0);

    // Unaligned PC and PC-4 wrap-around
    trap(32'h3013, 1'b0, 5'd6, 6'd0); rd(5'd14, 0); eret(0);
    trap(32'h0000_0002, 1'b1, 5'd7, 6'd0); rd(5'd14, 0); eret(0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rst;
      logic [4:0] exc;
      logic [5:0] hw;
      rst = ($urandom_range(0, 199) != 0);
      exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      step(rst, $urandom, 1'($urandom), exc, hw, 5'($urandom_range(10, 16)),
           ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 5) == 0));
    end

    step(1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
